serial_adder: RTL



---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/fulladder.sv | 16 +
 rtl/serial_adder.sv | 103 ++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding, default width and counter sizing helper
//   (no ports; imported by serial_adder)
package serial_adder_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit counter must hold 0..w-1 but never collapse to zero bits when w == 1
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/fulladder.sv
// fulladder: 1-bit full adder used as the serial bit-slice
//   a, b, cin : addend bits and carry-in
//   sum       : sum bit
//   carry     : carry-out
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one bit per clock LSB first through a single full adder
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : load a/b/cin and begin an add (honoured in IDLE or DONE)
//   a, b, cin   : operands and carry-in
//   busy        : high while bits are being processed
//   done        : one-cycle pulse when sum/cout are updated
//   sum, cout   : registered result, held until the next completion
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_w(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [WIDTH-1:0] shift_s_q, shift_s_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             fa_sum, fa_carry;
    logic             run, last, load;
    logic [WIDTH:0]   s_next;

    fulladder u_fa (
        .a    (shift_a_q[0]),
        .b    (shift_b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .carry(fa_carry)
    );

    assign run  = (state_q == RUN);
    assign last = (cnt_q == CW'(WIDTH - 1));
    assign load = start && !run;
    // Shift the new bit in at the MSB; written via a WIDTH+1 shift so WIDTH == 1 needs no special case
    assign s_next = {fa_sum, shift_s_q} >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = run ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    end

    always_comb begin
        busy = run;
        done = (state_q == DONE);
    end

    always_comb begin
        shift_a_d = load ? a   : (run ? shift_a_q >> 1 : shift_a_q);
        shift_b_d = load ? b   : (run ? shift_b_q >> 1 : shift_b_q);
        carry_d   = load ? cin : (run ? fa_carry : carry_q);
        cnt_d     = load ? '0  : (run ? cnt_q + CW'(1) : cnt_q);
        shift_s_d = run ? s_next[WIDTH-1:0] : shift_s_q;
        sum_d     = (run && last) ? s_next[WIDTH-1:0] : sum_q;
        cout_d    = (run && last) ? fa_carry : cout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_a_q <= '0;
            shift_b_q <= '0;
            shift_s_q <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else begin
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            shift_s_q <= shift_s_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
